// File: rtl/signed_divider_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package signed_divider_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_ITERS = 32;
   localparam int unsigned CNT_W     = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_ITER = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/signed_divider_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step
   import signed_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted;
   logic           fits;

   always_comb begin
      // rem_in is always below dvsr, so its top bit is zero and can be shifted out
      shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
      fits    = (shifted >= {1'b0, dvsr});
      rem_out = fits ? (shifted - {1'b0, dvsr}) : shifted;
      quo_out = {quo_in[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed divider: sign handling and control around a restoring step.
module signed_divider
   import signed_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             GO,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [1:0]       CS,
   output logic [5:0]       cnt,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   quotient_q, quotient_d;
   logic [WIDTH-1:0]   remainder_q, remainder_d;
   logic               dbz_q, dbz_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     step_rem;
   logic [WIDTH-1:0]   step_quo;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .dvsr    (dvsr_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      dvsr_d      = dvsr_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      done_d      = done_q;

      unique case (state_q)
         ST_IDLE: begin
            if (GO) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               dbz_d   = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // Zero divisor spends a second LOAD cycle: the flag rises first, then DONE.
            if (dbz_q) begin
               quotient_d  = '1;
               remainder_d = dvd_q;
               done_d      = 1'b1;
               state_d     = ST_DONE;
            end else if (dvs_q == '0) begin
               dbz_d = 1'b1;
            end else begin
               quo_d     = dvd_q[WIDTH-1] ? ('0 - dvd_q) : dvd_q;
               dvsr_d    = dvs_q[WIDTH-1] ? ('0 - dvs_q) : dvs_q;
               neg_quo_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
               neg_rem_d = dvd_q[WIDTH-1];
               rem_d     = '0;
               cnt_d     = '0;
               state_d   = ST_ITER;
            end
         end
         ST_ITER: begin
            if (cnt_q == CNT_W'(DIV_ITERS)) begin
               quotient_d  = neg_quo_q ? ('0 - quo_q) : quo_q;
               remainder_d = neg_rem_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
               done_d      = 1'b1;
               state_d     = ST_DONE;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (!GO) begin
               done_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         dvsr_q      <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         dvsr_q      <= dvsr_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         done_q      <= done_d;
      end
   end

   assign done        = done_q;
   assign CS          = state_q;
   assign cnt         = cnt_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_divider.sv
// Directed checks of signed_divider results, latency, hold behaviour and reset abort.
module tb_signed_divider;

   logic        clk = 1'b0;
   logic        RST;
   logic        GO;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        done;
   logic [1:0]  CS;
   logic [5:0]  cnt;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int n_cmp = 0;
   int n_err = 0;
   int lat;

   signed_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .RST         (RST),
      .GO          (GO),
      .dividend    (dividend),
      .divisor     (divisor),
      .done        (done),
      .CS          (CS),
      .cnt         (cnt),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sample GO at one edge, then count edges until done (bounded).
   task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic hold_go,
                                 output int n);
      dividend = a;
      divisor  = b;
      GO       = 1'b1;
      tick();
      GO = hold_go;
      n  = 0;
      while (done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      RST = 1'b1; GO = 1'b1; dividend = 32'd55; divisor = 32'd3;
      tick(); tick();
      check("rst_cs", 64'(CS), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cnt", 64'(cnt), 64'd0);
      check("rst_quo", 64'(quotient), 64'd0);
      check("rst_rem", 64'(remainder), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      RST = 1'b0; GO = 1'b0;
      tick();

      // 100 / 7 with GO held high throughout
      start_and_wait(32'd100, 32'd7, 1'b1, lat);
      check("p_lat", 64'(lat), 64'd34);
      check("p_quo", 64'(quotient), 64'h0000000E);
      check("p_rem", 64'(remainder), 64'h00000002);
      check("p_cs", 64'(CS), 64'd3);
      for (int i = 0; i < 5; i++) begin
         dividend = 32'hDEAD0000 + 32'(i);
         tick();
         check("hold_quo", 64'(quotient), 64'h0000000E);
         check("hold_rem", 64'(remainder), 64'h00000002);
         check("hold_cs", 64'(CS), 64'd3);
      end
      GO = 1'b0;
      tick();
      check("idle_cs", 64'(CS), 64'd0);
      check("idle_done", 64'(done), 64'd0);

      // -7 / 2, GO dropped and operands scrambled during ITER
      dividend = 32'hFFFFFFF9; divisor = 32'h2; GO = 1'b1;
      tick();
      GO = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (cnt == 6'd5) begin
            dividend = 32'h7FFFFFFF; divisor = 32'h0; GO = 1'b1;
         end
         if (cnt == 6'd7) GO = 1'b0;
         if (lat == 10) check("mid_quo_stable", 64'(quotient), 64'h0000000E);
         tick();
         lat++;
      end
      check("n_lat", 64'(lat), 64'd34);
      check("n_quo", 64'(quotient), 64'hFFFFFFFD);
      check("n_rem", 64'(remainder), 64'hFFFFFFFF);
      tick();

      // -100 / 7 and 7 / -100
      start_and_wait(32'hFFFFFF9C, 32'd7, 1'b0, lat);
      check("m_quo", 64'(quotient), 64'hFFFFFFF2);
      check("m_rem", 64'(remainder), 64'hFFFFFFFE);
      tick();
      start_and_wait(32'd7, 32'hFFFFFF9C, 1'b0, lat);
      check("s_quo", 64'(quotient), 64'h00000000);
      check("s_rem", 64'(remainder), 64'h00000007);
      tick();

      // Divide by zero
      start_and_wait(32'h12345678, 32'h0, 1'b0, lat);
      check("z_lat", 64'(lat), 64'd2);
      check("z_dbz", 64'(div_by_zero), 64'd1);
      check("z_quo", 64'(quotient), 64'hFFFFFFFF);
      check("z_rem", 64'(remainder), 64'h12345678);
      tick();

      // Most negative / -1
      start_and_wait(32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
      check("o_quo", 64'(quotient), 64'h80000000);
      check("o_rem", 64'(remainder), 64'h00000000);
      check("o_dbz", 64'(div_by_zero), 64'd0);
      tick();

      // Reset abort at cnt == 10
      dividend = 32'd1000; divisor = 32'd3; GO = 1'b1;
      tick();
      GO = 1'b0;
      lat = 0;
      while (cnt !== 6'd10 && lat < 100) begin
         tick();
         lat++;
      end
      check("abort_reach", 64'(cnt), 64'd10);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort_cs", 64'(CS), 64'd0);
      check("abort_cnt", 64'(cnt), 64'd0);
      check("abort_quo", 64'(quotient), 64'd0);
      check("abort_rem", 64'(remainder), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      start_and_wait(32'd12, 32'hFFFFFFFC, 1'b0, lat);
      check("r_lat", 64'(lat), 64'd34);
      check("r_quo", 64'(quotient), 64'hFFFFFFFD);
      check("r_rem", 64'(remainder), 64'h00000000);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port GO  input  1  start request, level-sensitive.
REQ-005 SHALL have port dividend  input  WIDTH  two's-complement dividend.
REQ-006 SHALL have port divisor  input  WIDTH  two's-complement divisor.
REQ-007 SHALL have port done  output  1  result valid, high exactly while CS==DONE.
REQ-008 SHALL have port CS  output  2  current state: IDLE=00, LOAD=01, ITER=10, DONE=11.
REQ-009 SHALL have port cnt  output  6  iteration counter, 0..32.
REQ-010 SHALL have port quotient  output  WIDTH  signed quotient, truncated toward zero.
REQ-011 SHALL have port remainder  output  WIDTH  signed remainder, same sign as dividend or zero.
REQ-012 SHALL have port div_by_zero  output  1  flag, set when the captured divisor == 0.

Function
REQ-013 IDLE: GO=1 at an edge SHALL capture dividend/divisor and go to LOAD; GO=0 SHALL stay in IDLE.
REQ-014 LOAD: divisor==0 SHALL go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-015 LOAD, divisor!=0: SHALL form unsigned WIDTH-bit magnitudes, record both signs, clear partial remainder, set cnt=0, go to ITER.
REQ-016 ITER: one restoring step per cycle SHALL run: shift {rem,quo} left 1; subtract |divisor| if rem>=|divisor| and set quo LSB=1; cnt+1.
REQ-017 Partial remainder datapath SHALL be WIDTH+1 bits so the 0x80000000 magnitude never overflows.
REQ-018 When cnt reaches 32, the next edge SHALL register sign-corrected results and enter DONE.
REQ-019 Sign correction: quotient negated iff operand signs differ; remainder negated iff dividend negative.
REQ-020 -2^31 / -1 SHALL yield quotient=0x80000000, remainder=0, div_by_zero=0; no special path.
REQ-021 Latency: done SHALL rise 34 edges after the GO-sampling edge for divisor!=0, and 2 edges after it for divisor==0.
REQ-022 DONE: quotient/remainder/div_by_zero SHALL hold stable; stay while GO=1; GO=0 SHALL return to IDLE.
REQ-023 GO and operand changes during LOAD/ITER SHALL be ignored; operands are sampled only in IDLE.
REQ-024 quotient/remainder SHALL change only on entry to DONE and on reset; no intermediate values visible.
REQ-025 A new operation starting from IDLE SHALL clear div_by_zero on the LOAD edge.

Reset
REQ-026 RST=1 at an edge SHALL force CS=IDLE, done=0, cnt=0, quotient=0, remainder=0, div_by_zero=0, internal registers=0.
REQ-027 RST SHALL take priority over GO and over every state, including mid-ITER; the aborted result is discarded.
REQ-028 After reset is released, the first GO=1 edge SHALL start a new operation normally.

Structure
REQ-029 The shared package SHALL hold the state encoding constants, WIDTH default, and iteration count constant (32).
REQ-030 One sub-module, div_step, SHALL be instantiated: a combinational single restoring step (shift, compare, subtract, quotient bit).
REQ-031 Sign handling and the FSM SHALL stay in signed_divider.

Verification
REQ-032 100 / 7, GO held high -> done at edge 34, quotient=0x0000000E, remainder=0x00000002, CS=11.
REQ-033 -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-034 0x12345678 / 0 -> done at edge 2, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x12345678.
REQ-035 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-036 RST pulsed at cnt=10 -> next edge CS=00, all outputs 0; new GO with 12/-4 -> quotient=0xFFFFFFFD, remainder=0.
REQ-037 GO held after done -> outputs stable for 5 cycles; GO low -> IDLE; operands changed mid-ITER -> no effect on result.
